// File: rtl/mem_lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   lsu_state_e         - FSM states (IDLE / REQ / WAIT_R)
//   F3_*                - func3 access width/sign encodings
//   LSU_TIMEOUT_DEFAULT - default bus-cycle budget per access
//   LSU_CNT_W           - width of the timeout counter
//   misaligned()        - access alignment rule shared by the FSM
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_TIMEOUT_DEFAULT = 255;
  localparam int LSU_CNT_W           = 8;

  // Width lives in func3[1:0]; bit 2 only selects zero-extension.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = lo[0];
      default: r = (lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational byte-lane steering for the LSU.
//   Store side: i_st_size/i_st_lo/i_st_data -> o_be, o_wdata (lane replication)
//   Load side : i_ld_func3/i_ld_lo/i_rdata  -> o_ld_data (extract + extend)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_func3,
  input  logic [1:0]  i_ld_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Replicating the source across lanes lets the byte enables alone pick
  // which lanes the memory actually writes.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_size)
      2'b00: begin
        o_be    = 4'b0001 << i_st_lo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << i_st_lo;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_half = i_ld_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_byte = i_ld_lo[0] ? w_half[15:8]   : w_half[7:0];

  always_comb begin
    case (i_ld_func3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage load/store unit with a req/gnt + rvalid data bus.
//   i_alu_out/i_rs2_data/i_dm_w_en/i_wb_sel/i_func3/i_rd_index : E/M access
//   o_dmem_* / i_dmem_*   : bus request side (one outstanding access)
//   o_lsu_stall           : holds IF..E/M while an access is in flight
//   o_ld_valid/_data/_rd  : load completion, extended data, destination
//   o_misalign/o_bus_err  : one-cycle fault pulses; o_fault_addr holds addr
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs2_data,
  input  logic [3:0]  i_dm_w_en,
  input  logic        i_wb_sel,
  input  logic [2:0]  i_func3,
  input  logic [4:0]  i_rd_index,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_lsu_stall,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  output logic [4:0]  o_ld_rd,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic [31:0] o_fault_addr
);

  localparam logic [LSU_CNT_W-1:0] CNT_LAST = LSU_CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e           r_state, w_next;
  logic [LSU_CNT_W-1:0] r_cnt;
  logic [31:0]          r_addr, r_wdata, r_fault;
  logic [3:0]           r_be;
  logic                 r_we;
  logic [2:0]           r_func3;
  logic [4:0]           r_rd;

  logic        w_access, w_misal, w_capture, w_timeout;
  logic        w_req, w_stall, w_ldv, w_mis, w_berr;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_access  = i_wb_sel | (|i_dm_w_en);
  assign w_misal   = misaligned(i_func3, i_alu_out[1:0]);
  assign w_capture = w_access & ~w_misal;
  // >= rather than ==: a load granted on the last budget cycle still
  // times out in its first WAIT_R cycle instead of wrapping the counter.
  assign w_timeout = (r_cnt >= CNT_LAST);

  lsu_align u_align (
    .i_st_size  (i_func3[1:0]),
    .i_st_lo    (i_alu_out[1:0]),
    .i_st_data  (i_rs2_data),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_func3 (r_func3),
    .i_ld_lo    (r_addr[1:0]),
    .i_rdata    (i_dmem_rdata),
    .o_ld_data  (o_ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_capture) w_next = ST_REQ;
      ST_REQ: begin
        if (i_dmem_gnt)     w_next = r_we ? ST_IDLE : ST_WAIT_R;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_WAIT_R: if (i_dmem_rvalid || w_timeout) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // A gnt/rvalid in the timeout cycle completes normally, so the error
  // branch is only reached when the bus did not answer.
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    w_ldv   = 1'b0;
    w_mis   = 1'b0;
    w_berr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_capture;
        w_mis   = w_access & w_misal;
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (i_dmem_gnt)     w_stall = ~r_we;
        else if (w_timeout) w_berr  = 1'b1;
        else                w_stall = 1'b1;
      end
      ST_WAIT_R: begin
        if (i_dmem_rvalid)  w_ldv  = 1'b1;
        else if (w_timeout) w_berr = 1'b1;
        else                w_stall = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_func3 <= '0;
      r_rd    <= '0;
      r_fault <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        if (w_capture) begin
          r_addr  <= i_alu_out;
          r_wdata <= w_wdata;
          r_be    <= w_be;
          r_we    <= ~i_wb_sel;
          r_func3 <= i_func3;
          r_rd    <= i_rd_index;
        end
      end else begin
        r_cnt <= r_cnt + LSU_CNT_W'(1);
      end
      if (w_mis)       r_fault <= i_alu_out;
      else if (w_berr) r_fault <= r_addr;
    end
  end

  assign o_dmem_req   = w_req & ~i_rst;
  assign o_dmem_we    = r_we & o_dmem_req;
  assign o_dmem_addr  = {r_addr[31:2], 2'b00};
  assign o_dmem_be    = r_be;
  assign o_dmem_wdata = r_wdata;
  assign o_lsu_stall  = w_stall & ~i_rst;
  assign o_ld_valid   = w_ldv & ~i_rst;
  assign o_ld_rd      = r_rd;
  assign o_misalign   = w_mis & ~i_rst;
  assign o_bus_err    = w_berr & ~i_rst;
  assign o_fault_addr = r_fault;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: the driver predicts bus writes, load results
// and faults from the access rules; a monitor pops and compares whenever the
// DUT shows a handshake, ld_valid or a fault pulse.
module tb_mem_lsu;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out, rs2_data, dmem_addr, dmem_wdata, dmem_rdata, ld_data, fault_addr;
  logic [3:0]  dm_w_en, dmem_be;
  logic        wb_sel, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic        lsu_stall, ld_valid, misalign, bus_err;
  logic [2:0]  func3;
  logic [4:0]  rd_index, ld_rd;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_alu_out(alu_out), .i_rs2_data(rs2_data),
    .i_dm_w_en(dm_w_en), .i_wb_sel(wb_sel), .i_func3(func3), .i_rd_index(rd_index),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata), .i_dmem_gnt(dmem_gnt),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata), .o_lsu_stall(lsu_stall),
    .o_ld_valid(ld_valid), .o_ld_data(ld_data), .o_ld_rd(ld_rd),
    .o_misalign(misalign), .o_bus_err(bus_err), .o_fault_addr(fault_addr)
  );

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; } ld_t;
  typedef struct { logic berr; logic [31:0] addr; } flt_t;
  typedef struct { int gd; int rdl; logic [31:0] rdata; } slv_t;

  bus_t bus_q[$];
  ld_t  ld_q[$];
  flt_t flt_q[$];
  slv_t slv_q[$];

  int errors = 0;
  int checks = 0;
  int berr_cnt = 0;
  bit force_rv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with nothing predicted (t=%0t)", name, $time);
  endtask

  // Bus slave: gnt after gd REQ cycles, rvalid after rdl further WAIT cycles,
  // plus stray rvalids outside a data phase that the DUT has to ignore.
  initial begin
    int ph, cnt, seen;
    slv_t cur;
    ph = 0; cnt = 0; seen = 0;
    cur = '{0, 0, 32'h0};
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
      if (rst || seen != berr_cnt) ph = 0;
      seen = berr_cnt;
      if (force_rv) dmem_rvalid = 1;
      else if (!rst) begin
        if (ph == 0 && dmem_req) begin
          if (slv_q.size() > 0) cur = slv_q.pop_front();
          else cur = '{0, 0, 32'h0};
          cnt = 0; ph = 1;
        end
        if (ph == 1) begin
          if (cnt == cur.gd) begin
            dmem_gnt = 1; cnt = 0;
            ph = dmem_we ? 0 : 2;
          end else cnt++;
        end else if (ph == 2) begin
          if (cnt == cur.rdl) begin
            dmem_rvalid = 1; dmem_rdata = cur.rdata; ph = 0;
          end else cnt++;
        end
        if (ph <= 1 && !dmem_rvalid && $urandom_range(0, 7) == 0) dmem_rvalid = 1;
      end
    end
  end

  // Monitor
  initial begin
    bit pend_v, hold;
    logic [31:0] pend_a, p_addr, p_wdata;
    logic [3:0] p_be;
    logic p_we;
    bus_t b; ld_t l; flt_t f;
    pend_v = 0; hold = 0; pend_a = 0; p_addr = 0; p_wdata = 0; p_be = 0; p_we = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        chk("reset_outputs", {27'd0, dmem_req, lsu_stall, ld_valid, misalign, bus_err}, 32'd0);
        pend_v = 0; hold = 0;
      end else begin
        if (pend_v) begin chk("fault_addr", fault_addr, pend_a); pend_v = 0; end
        if (misalign || bus_err) begin
          if (bus_err) berr_cnt++;
          if (flt_q.size() == 0) unexpected("fault_pulse");
          else begin
            f = flt_q.pop_front();
            chk("fault_kind", {30'd0, misalign, bus_err}, {30'd0, ~f.berr, f.berr});
            pend_a = f.addr; pend_v = 1;
          end
        end
        if (dmem_req) chk("addr_word_aligned", {30'd0, dmem_addr[1:0]}, 32'd0);
        if (hold && dmem_req) begin
          chk("hold_addr", dmem_addr, p_addr);
          chk("hold_be_we", {27'd0, dmem_be, dmem_we}, {27'd0, p_be, p_we});
          chk("hold_wdata", dmem_wdata, p_wdata);
        end
        hold = dmem_req && !dmem_gnt;
        p_addr = dmem_addr; p_be = dmem_be; p_we = dmem_we; p_wdata = dmem_wdata;
        if (dmem_req && dmem_gnt) begin
          if (bus_q.size() == 0) unexpected("bus_handshake");
          else begin
            b = bus_q.pop_front();
            chk("bus_addr", dmem_addr, b.addr);
            chk("bus_we_be", {27'd0, dmem_we, dmem_be}, {27'd0, b.we, b.be});
            if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
          end
        end
        if (ld_valid) begin
          if (ld_q.size() == 0) unexpected("ld_valid");
          else begin
            l = ld_q.pop_front();
            chk("ld_data", ld_data, l.data);
            chk("ld_rd", {27'd0, ld_rd}, {27'd0, l.rd});
          end
        end
      end
    end
  end

  // Issue one access, predict its outcome, wait for stall to drop.
  task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rdi, input int gd,
                       input int rdl, input logic [31:0] rdat);
    int sz, lo, lat, cyc;
    logic [3:0] be;
    logic [31:0] wd, mask, ext;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lo = int'(a[1:0]);
    alu_out = a; rs2_data = d; func3 = f3; rd_index = rdi; wb_sel = ld;
    dm_w_en = ld ? 4'd0 : 4'($urandom_range(1, 15));
    if (lo % sz != 0) begin
      flt_q.push_back('{1'b0, a});
      lat = 1;
    end else begin
      be = 0; wd = 0;
      for (int i = 0; i < 4; i++) begin
        if (i >= lo && i < lo + sz) be[i] = 1'b1;
        wd[8*i +: 8] = d[8*(i % sz) +: 8];
      end
      slv_q.push_back('{gd, rdl, rdat});
      if (gd + 1 > T) begin
        flt_q.push_back('{1'b1, a});
        lat = 1 + T;
      end else begin
        bus_q.push_back('{a & 32'hFFFF_FFFC, ~ld, be, wd});
        if (!ld) lat = gd + 2;
        else if (gd + rdl + 2 <= T) begin
          mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
          ext = (rdat >> (8 * lo)) & mask;
          if (sz < 4 && !f3[2] && ext[8*sz-1]) ext = ext | ~mask;
          ld_q.push_back('{ext, rdi});
          lat = gd + rdl + 3;
        end else begin
          flt_q.push_back('{1'b1, a});
          lat = 1 + ((gd + 2 > T) ? gd + 2 : T);
        end
      end
    end
    cyc = 0;
    do begin @(negedge clk); #2; cyc++; end while (lsu_stall && cyc < 40);
    chk("stall_cycles", cyc, lat);
    @(posedge clk); #1;
    wb_sel = 0; dm_w_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ld;
    logic [2:0] f3;
    logic [31:0] a;
    int sz;
    logic [2:0] lf3 [5];
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
    rst = 1; alu_out = 0; rs2_data = 0; dm_w_en = 0; wb_sel = 0; func3 = 0; rd_index = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #2;
    chk("post_reset_fault_addr", fault_addr, 32'd0);
    chk("post_reset_idle", {30'd0, dmem_req, lsu_stall}, 32'd0);
    @(posedge clk); #1;

    issue(0, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0);
    issue(1, 3'b000, 32'h203, 32'h0, 5'd7, 0, 0, 32'h80FF_0000);
    issue(1, 3'b101, 32'h202, 32'h0, 5'd9, 0, 1, 32'h8001_1234);
    issue(0, 3'b001, 32'h101, 32'h1234, 5'd0, 0, 0, 32'h0);
    issue(0, 3'b010, 32'h140, 32'h55, 5'd0, 9, 0, 32'h0);
    issue(0, 3'b000, 32'h3, 32'hA5, 5'd0, 1, 0, 32'h0);

    // Reset lands while a load waits for data; a later rvalid must be ignored.
    alu_out = 32'h300; wb_sel = 1; dm_w_en = 0; func3 = 3'b010; rd_index = 5'd3;
    slv_q.push_back('{0, 20, 32'h1234_5678});
    bus_q.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
    @(negedge clk); #2; chk("rstw_idle_stall", {31'd0, lsu_stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); #2; chk("rstw_gnt_stall", {31'd0, lsu_stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); #2; chk("rstw_wait_stall", {31'd0, lsu_stall}, 32'd1);
    @(posedge clk); #1; rst = 1; wb_sel = 0;
    @(posedge clk); #1; rst = 0; force_rv = 1;
    repeat (3) begin
      @(negedge clk); #2;
      chk("late_rvalid_ignored", {29'd0, ld_valid, dmem_req, lsu_stall}, 32'd0);
    end
    @(posedge clk); #1; force_rv = 0;

    for (int n = 0; n < 160; n++) begin
      ld = $urandom_range(0, 1);
      f3 = ld ? lf3[$urandom_range(0, 4)] : lf3[$urandom_range(0, 2)];
      sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      a = $urandom_range(0, 4095);
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(sz) - 32'd1);
      issue(ld, f3, a, $urandom, 5'($urandom), ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2)
            : $urandom_range(3, 6), $urandom_range(0, 2), $urandom);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    repeat (5) @(posedge clk);
    @(negedge clk); #3;
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
    chk("flt_q_drained", 32'(flt_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, bus cycles allowed per access before an error is declared.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alu_out  in  32  effective byte address from the E/M stage register.
REQ-005 rs2_data  in  32  store source data.
REQ-006 dm_w_en  in  4  nonzero marks a store; the bit pattern is otherwise ignored.
REQ-007 wb_sel  in  1  1 marks a load.
REQ-008 func3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 rd_index  in  5  load destination register.
REQ-010 dmem_req, dmem_we  out  1,1  bus request and write strobe.
REQ-011 dmem_addr  out  32  word-aligned address, bits [1:0] = 0.
REQ-012 dmem_be, dmem_wdata  out  4,32  byte enables and write data.
REQ-013 dmem_gnt, dmem_rvalid  in  1,1  request accepted; read data valid.
REQ-014 dmem_rdata  in  32  read data.
REQ-015 lsu_stall  out  1  freezes IF through E/M while high.
REQ-016 ld_valid, ld_data, ld_rd  out  1,32,5  load completion, extended result, and destination.
REQ-017 misalign, bus_err  out  1,1  single-cycle fault pulses.
REQ-018 fault_addr  out  32  faulting alu_out, held until the next fault.

Function
- REQ-019 FSM states: IDLE, REQ, WAIT_R.
- REQ-020 An access is present when wb_sel=1 or dm_w_en!=0.
- REQ-021 IDLE, aligned access present: lsu_stall=1 in that cycle; capture addr, be, wdata, we, func3, rd_index; next state REQ.
- REQ-022 Misalignment rule: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
- REQ-023 IDLE, misaligned access: misalign=1 for one cycle; fault_addr=alu_out; no bus request; lsu_stall=0; state stays IDLE.
- REQ-024 REQ: dmem_req=1; addr/we/be/wdata held stable until dmem_gnt sampled high.
- REQ-025 REQ, gnt, store: the store completes; lsu_stall=0 in the gnt cycle; next state IDLE.
- REQ-026 REQ, gnt, load: next state WAIT_R; lsu_stall stays 1.
- REQ-027 WAIT_R, rvalid: ld_valid=1 combinationally in the same cycle; ld_data driven from dmem_rdata; lsu_stall=0; next state IDLE.
- REQ-028 Outside WAIT_R, dmem_rvalid is ignored.
- REQ-029 Minimum latency: store 2 cycles; load 3 cycles (IDLE, REQ with gnt, WAIT_R with rvalid).
- REQ-030 Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
- REQ-031 Write data: SB replicates byte [7:0] x4; SH replicates [15:0] x2; SW is unchanged.
- REQ-032 Load extraction: select the byte or halfword by addr[1:0]; B/H sign-extend; BU/HU zero-extend; W unchanged.
- REQ-033 Timeout counter: 8-bit, cleared on entry to REQ, increments each REQ/WAIT_R cycle.
- REQ-034 Timeout event: on reaching TIMEOUT_CYCLES, bus_err pulses one cycle; fault_addr=captured addr; dmem_req drops; lsu_stall=0; next state IDLE.
- REQ-035 A gnt or rvalid arriving in the same cycle as timeout wins; no bus_err.
- REQ-036 Back-to-back accesses: the E/M register advances in the completion cycle, and the next access is recognized in IDLE the following cycle with no dead cycle.

Reset
- REQ-037 rst high at posedge: state=IDLE, counter=0, captured registers=0, fault_addr=0.
- REQ-038 While rst is high: dmem_req, lsu_stall, ld_valid, misalign, bus_err forced 0.
- REQ-039 Reset mid-access abandons the transaction; a late rvalid is ignored per REQ-028.

Structure
- REQ-040 The shared package (lsu_pkg) holds: FSM state enum, func3 width encodings, and the default for TIMEOUT_CYCLES.
- REQ-041 Sub-module lsu_align: combinational; computes be, wdata replication, and load extraction/extension.
- REQ-042 The FSM and timeout counter stay in mem_lsu.

Verification
- REQ-043 SW addr 0x100, data 0xDEADBEEF, gnt in first REQ cycle -> be=1111, wdata=0xDEADBEEF, stall high 1 cycle then low at gnt.
- REQ-044 LB addr 0x203, rdata 0x80FF_0000 -> ld_data=0xFFFFFF80, ld_rd matches the captured rd_index, ld_valid=1 in the rvalid cycle only.
- REQ-045 LHU addr 0x202, rdata 0x8001_1234 -> ld_data=0x00008001.
- REQ-046 SH addr 0x101 -> misalign pulse, fault_addr=0x101, dmem_req never asserted.
- REQ-047 gnt withheld with TIMEOUT_CYCLES=4 -> bus_err after 4 REQ cycles, then stall=0 and state IDLE.
- REQ-048 rst asserted in WAIT_R, then rvalid -> ld_valid stays 0, state IDLE.
